bk_sub_pipe: RTL
================

// Module: bk_sub_pipe
// PURPOSE
//  Pipelined 16-bit Brent-Kung subtractor: diff = a - b - borrow, computed as a + ~b + carry.
//  Streams multi-word (multi-precision) operands, least-significant word first, with the
//  borrow chained between words.
//  Produces per-word difference plus packet-level zero / less-than flags.
//  Sits beside the brentkung adder as the subtract/compare path of the arithmetic datapath.
// PARAMETERS
//  WIDTH       16  word width; only 16 is supported (fixed 4-level prefix tree)
//  SIGNED_CMP  0   0: lt = unsigned borrow on last word; 1: lt = sign ^ overflow on last word
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   input word valid
//  in_ready   out  1   input word accepted when in_valid & in_ready
//  in_first   in   1   word is least-significant of a packet (no borrow in)
//  in_last    in   1   word is most-significant of a packet
//  a          in   16  minuend word
//  b          in   16  subtrahend word
//  out_valid  out  1   result word valid
//  out_ready  in   1   result consumed when out_valid & out_ready
//  diff       out  16  a - b - borrow_in for this word
//  borrow_out out  1   borrow out of this word (= ~carry16)
//  out_last   out  1   copy of in_last for this word
//  zero       out  1   all diff words of packet so far are 0 (final on out_last)
//  lt         out  1   a < b for the whole packet; valid only with out_last
//  err        out  1   one-cycle pulse: in_first=0 word accepted while not in a packet
// BEHAVIOUR
//  - Reset values: out_valid 0, diff 0, borrow_out 0, out_last 0, zero 0, lt 0, err 0.
//    Stage valids 0. FSM in IDLE. carry_reg 1.
//  - After reset, in_ready = 1.
//  - Stage 1 (S1) registers the word and first/last flags.
//    It also registers bitwise p = a^~b and g = a&~b, plus all group P/G terms of
//    levels 2..5 (pairs, quads, octets, 16). These terms are carry-independent.
//  - Stage 2 (S2) forms every carry from the group terms and the carry-in (Brent-Kung
//    back-tree), then registers the outputs.
//    Carry-in: cin = S1.first ? 1 : carry_reg. diff = p ^ c[15:0]. borrow_out = ~c16.
//  - carry_reg <= c16 on each S2 load. A word therefore sees its predecessor's carry with
//    no bubble: back-to-back words stream at 1 word/clk.
//  - Latency: 2 clk from input handshake to out_valid when not stalled.
//  - Flow control: adv = ~out_valid | out_ready. S2 loads when adv. S1 loads when in_ready.
//    in_ready = ~s1_valid | adv. Stall freezes both stages, carry_reg, flags and FSM.
//  - Sequence guarantees: no drop, no duplicate, order preserved under any out_ready pattern.
//  - zero <= (S1.first ? 1 : zero) & (diff == 0).
//  - lt on an out_last word:
//    SIGNED_CMP=0: lt = borrow_out.
//    SIGNED_CMP=1: lt = diff[15] ^ ovf, where ovf = c15 ^ c16.
//    lt = 0 on words without out_last.
//  - FSM, advanced on input handshake:
//    IDLE --first&~last--> IN_PKT.
//    IN_PKT --last--> IDLE.
//    first&last is a single-word packet and stays in IDLE.
//    first=1 while in IN_PKT starts a new packet; the old one is abandoned and no err.
//    first=0 while in IDLE: err pulses the cycle after the handshake. The word is still
//    processed with carry_reg, which is 1 after reset or last. FSM -> IN_PKT unless last.
//  - Reset mid-packet: in-flight words are discarded and no output for them is emitted.
//    carry_reg -> 1 and FSM -> IDLE.
//  - Arithmetic is modulo 2^16 per word. No saturation. Carry-out is exposed only via borrow_out.
// STRUCTURE
//  - Shared package: WIDTH_C = 16; FSM state enum {IDLE, IN_PKT}; pg_t struct {p, g}.
//  - One sub-module, bk_prefix_core. It is combinational and has two functions:
//    (a) up-sweep of group P/G from bitwise p/g;
//    (b) down-sweep producing c[16:1] from group terms and cin.
//    S1 instantiates (a); S2 instantiates (b).
//  - Top level holds S1/S2 registers, carry_reg, zero/lt logic, handshake and FSM.
// TESTING
//  - Single word: first=last=1, a=0x1234, b=0x0234.
//    -> 2 clk later diff=0x1000, borrow_out=0, zero=0, lt=0.
//  - Single word: a=0x0000, b=0x0001.
//    -> diff=0xFFFF, borrow_out=1, lt=1.
//    With SIGNED_CMP=1 and a=0x8000, b=0x0001: lt=1, diff=0x7FFF.
//  - 2-word packet, LS word first: a=0x0001_0000, b=0x0000_0001.
//    -> word0 diff=0xFFFF, borrow_out=1.
//    -> word1 diff=0x0000, borrow_out=0, zero=0, lt=0.
//  - 2-word equal operands 0xBEEF_CAFE - 0xBEEF_CAFE, sent back-to-back.
//    -> both diff=0; zero=1 on last; lt=0; no bubble between out_valid cycles.
//  - Stream of 8 single-word packets with out_ready toggling 1,0,1,0.
//    -> all 8 results in order, each matching a-b. in_ready low only while both stages are
//    full and blocked.
//  - Reset asserted 1 clk after word0 (first=1, last=0) is accepted.
//    -> no output for word0. Then send first=0, a=5, b=3 -> err pulse, diff=0x0002.

Source files
------------

// File: rtl/bk_sub_pipe_pkg.sv
// Shared types and helpers for the pipelined Brent-Kung subtractor.
// Group terms are kept as (propagate, generate) pairs per prefix-tree node.
package bk_sub_pipe_pkg;

    localparam int WIDTH_C = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Level 2 = bit pairs, level 3 = quads, level 4 = octets, level 5 = full word.
    typedef struct packed {
        pg_t       l5;
        pg_t [1:0] l4;
        pg_t [3:0] l3;
        pg_t [7:0] l2;
    } grp_t;

    function automatic pg_t pg_comb(input pg_t hi, input pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

    function automatic logic pg_carry(input pg_t t, input logic c);
        return t.g | (t.p & c);
    endfunction

endpackage

// File: rtl/bk_prefix_core.sv
// Combinational 16-bit Brent-Kung prefix core: up-sweep of group P/G terms and
// down-sweep of carries c[16:1] from those terms plus the carry-in.
module bk_prefix_core
    import bk_sub_pipe_pkg::*;
(
    input  pg_t [WIDTH_C-1:0] bit_pg,
    input  grp_t              grp_in,
    input  logic              cin,
    output grp_t              grp_out,
    output logic [WIDTH_C:1]  carry
);

    logic [WIDTH_C:0] c;
    logic             grp_unused;

    always_comb begin
        grp_out = '0;
        for (int j = 0; j < 8; j++) grp_out.l2[j] = pg_comb(bit_pg[2*j+1], bit_pg[2*j]);
        for (int j = 0; j < 4; j++) grp_out.l3[j] = pg_comb(grp_out.l2[2*j+1], grp_out.l2[2*j]);
        for (int j = 0; j < 2; j++) grp_out.l4[j] = pg_comb(grp_out.l3[2*j+1], grp_out.l3[2*j]);
        grp_out.l5 = pg_comb(grp_out.l4[1], grp_out.l4[0]);
    end

    // Back-tree: power-of-two carries come straight from the spans rooted at bit 0,
    // the rest fill in from the nearest lower carry.
    always_comb begin
        c     = '0;
        c[0]  = cin;
        c[16] = pg_carry(grp_in.l5, cin);
        c[8]  = pg_carry(grp_in.l4[0], cin);
        c[4]  = pg_carry(grp_in.l3[0], cin);
        c[12] = pg_carry(grp_in.l3[2], c[8]);
        for (int j = 0; j < 4; j++) c[4*j+2] = pg_carry(grp_in.l2[2*j], c[4*j]);
        for (int j = 0; j < 8; j++) c[2*j+1] = pg_carry(bit_pg[2*j], c[2*j]);
    end

    assign carry = c[WIDTH_C:1];

    // Interior nodes only the up-sweep needs.
    assign grp_unused = ^{grp_in.l4[1], grp_in.l3[1], grp_in.l3[3],
                          grp_in.l2[1], grp_in.l2[3], grp_in.l2[5], grp_in.l2[7]};

endmodule

// File: rtl/bk_sub_pipe.sv
// Two-stage streaming multi-word subtractor: S1 registers carry-independent P/G
// terms, S2 resolves carries with the chained borrow and registers the results.
module bk_sub_pipe
    import bk_sub_pipe_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             out_last,
    output logic             zero,
    output logic             lt,
    output logic             err
);

    localparam int STAGES = 2;

    logic [STAGES:1]    vld_pipe;
    state_t             state, state_nxt;
    logic               err_nxt, carry_reg, adv, in_hs, cin, lt_w;
    logic               s1_first, s1_last;
    pg_t [WIDTH_C-1:0]  in_bit, s1_bit;
    grp_t               in_grp, s1_grp, s2_grp_unused;
    logic [WIDTH_C:1]   c, s1_carry_unused;
    logic [WIDTH_C-1:0] d;

    assign adv       = ~vld_pipe[2] | out_ready;
    assign in_ready  = ~vld_pipe[1] | adv;
    assign in_hs     = in_valid & in_ready;
    assign out_valid = vld_pipe[2];

    // a + ~b: bitwise propagate/generate with b inverted.
    always_comb begin
        in_bit = '0;
        for (int i = 0; i < WIDTH_C; i++) begin
            in_bit[i].p = a[i] ^ ~b[i];
            in_bit[i].g = a[i] & ~b[i];
        end
    end

    bk_prefix_core u_up (
        .bit_pg  (in_bit),
        .grp_in  ('0),
        .cin     (1'b0),
        .grp_out (in_grp),
        .carry   (s1_carry_unused)
    );

    assign cin = s1_first ? 1'b1 : carry_reg;

    bk_prefix_core u_down (
        .bit_pg  (s1_bit),
        .grp_in  (s1_grp),
        .cin     (cin),
        .grp_out (s2_grp_unused),
        .carry   (c)
    );

    always_comb begin
        d = '0;
        for (int i = 0; i < WIDTH_C; i++) d[i] = s1_bit[i].p ^ (i == 0 ? cin : c[i]);
    end

    assign lt_w = SIGNED_CMP ? (d[WIDTH_C-1] ^ c[WIDTH_C-1] ^ c[WIDTH_C]) : ~c[WIDTH_C];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe   <= '0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s1_bit     <= '0;
            s1_grp     <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            out_last   <= 1'b0;
            zero       <= 1'b0;
            lt         <= 1'b0;
            err        <= 1'b0;
            carry_reg  <= 1'b1;
        end else begin
            if (in_ready) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_first <= in_first;
                    s1_last  <= in_last;
                    s1_bit   <= in_bit;
                    s1_grp   <= in_grp;
                end
            end
            if (adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    diff       <= d;
                    borrow_out <= ~c[WIDTH_C];
                    out_last   <= s1_last;
                    zero       <= (s1_first | zero) & (d == '0);
                    lt         <= s1_last & lt_w;
                    // A finished packet leaves a clean "no borrow" for whatever follows.
                    carry_reg  <= s1_last ? 1'b1 : c[WIDTH_C];
                end
            end
            err <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        if (in_hs) begin
            err_nxt   = ~in_first & (state == IDLE);
            state_nxt = in_last ? IDLE : IN_PKT;
        end
    end

endmodule
